// File: rtl/xfer_request_ctrl.sv
// Operator transfer-key conditioner: synchronizes and debounces the active-low key,
// fires a one-cycle xfer request when ready, then supervises the rdy_xfer acknowledge.
module xfer_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       rdy_xfer,
  output logic       xfer,
  output logic       busy,
  output logic       denied,
  output logic       timeout_err,
  output logic [7:0] xfer_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(1'b0);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1'b1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ZERO = TO_W'(1'b0);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1'b1);
  // Last WAIT_DROP cycle: the counter would reach TIMEOUT_CYCLES-1 at this edge.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  logic            sync1_r;
  logic            sync2_r;
  logic            db_r;
  logic            db_prev_r;
  logic [DB_W-1:0] db_cnt_r;
  state_t          state_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            xfer_r;
  logic            busy_r;
  logic            denied_r;
  logic            timeout_err_r;
  logic [7:0]      xfer_count_r;
  logic            press_s;

  // Press is the released-to-pressed edge of the debounced level only.
  assign press_s = (db_r == 1'b0) && (db_prev_r == 1'b1);

  // Two-flop synchronizer; reset value is the released level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_r      <= 1'b1;
      db_prev_r <= 1'b1;
      db_cnt_r  <= DB_ZERO;
    end else begin
      db_prev_r <= db_r;
      if (sync2_r != db_r) begin
        if (db_cnt_r == DB_LAST) begin
          db_r     <= sync2_r;
          db_cnt_r <= DB_ZERO;
        end else begin
          db_cnt_r <= db_cnt_r + DB_ONE;
        end
      end else begin
        db_cnt_r <= DB_ZERO;
      end
    end
  end

  // Transfer FSM with registered Moore outputs, completion counter and sticky timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      to_cnt_r      <= TO_ZERO;
      xfer_r        <= 1'b0;
      busy_r        <= 1'b0;
      denied_r      <= 1'b0;
      timeout_err_r <= 1'b0;
      xfer_count_r  <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (press_s && rdy_xfer) begin
            state_r  <= ST_FIRE;
            xfer_r   <= 1'b1;
            busy_r   <= 1'b1;
            denied_r <= 1'b0;
          end else begin
            state_r  <= ST_IDLE;
            xfer_r   <= 1'b0;
            busy_r   <= 1'b0;
            denied_r <= press_s;
          end
        end
        ST_FIRE: begin
          state_r  <= ST_WAIT;
          to_cnt_r <= TO_ZERO;
          xfer_r   <= 1'b0;
          busy_r   <= 1'b1;
          denied_r <= 1'b0;
        end
        ST_WAIT: begin
          xfer_r   <= 1'b0;
          denied_r <= 1'b0;
          // A drop on the final cycle still wins over the timeout.
          if (!rdy_xfer) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            xfer_count_r <= xfer_count_r + 8'd1;
          end else if (to_cnt_r == TO_LAST) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b1;
          end else begin
            state_r  <= ST_WAIT;
            busy_r   <= 1'b1;
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          to_cnt_r <= TO_ZERO;
          xfer_r   <= 1'b0;
          busy_r   <= 1'b0;
          denied_r <= 1'b0;
        end
      endcase
    end
  end

  assign xfer        = xfer_r;
  assign busy        = busy_r;
  assign denied      = denied_r;
  assign timeout_err = timeout_err_r;
  assign xfer_count  = xfer_count_r;

endmodule

// File: tb/tb_xfer_request_ctrl.sv
// Directed bench for xfer_request_ctrl: a per-cycle vector table for press/deny timing
// plus hand-written sequences for bounce, timeout, boundary drop, wrap and reset.
module tb_xfer_request_ctrl;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic       rdy_xfer;
  logic       xfer;
  logic       busy;
  logic       denied;
  logic       timeout_err;
  logic [7:0] xfer_count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       key_n;
    logic       rdy;
    logic       xfer;
    logic       busy;
    logic       denied;
    logic       terr;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [29];

  xfer_request_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .rdy_xfer   (rdy_xfer),
    .xfer       (xfer),
    .busy       (busy),
    .denied     (denied),
    .timeout_err(timeout_err),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic k, input logic r, input logic x, input logic b,
                              input logic d, input logic t, input logic [7:0] c);
    vec_t v;
    v.key_n = k; v.rdy = r; v.xfer = x; v.busy = b; v.denied = d; v.terr = t; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {xfer, busy, denied, timeout_err, xfer_count};
  endfunction

  // Wait (bounded) for an xfer pulse; returns sampled just after the firing edge.
  task automatic wait_xfer(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      step();
      if (xfer) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // One complete successful transfer, leaving the key released and rdy_xfer high.
  task automatic do_xfer();
    rdy_xfer = 1'b1;
    key_n    = 1'b0;
    wait_xfer("do_xfer_fire");
    rdy_xfer = 1'b0;
    repeat (2) step();
    key_n = 1'b1;
    repeat (8) step();
    rdy_xfer = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    logic any_act;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    key_n        = 1'b1;
    rdy_xfer     = 1'b0;

    for (int i = 0; i <= 5; i++)  vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[6] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 7; i <= 9; i++)  vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 10; i <= 11; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 12; i <= 19; i++) vecs[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 20; i <= 25; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    for (int i = 27; i <= 28; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Reset state, held and after release with the key idle.
    repeat (3) step();
    chk("reset_hold", {20'd0, outs()}, 32'd0);
    reset = 1'b1;
    repeat (3) step();
    chk("reset_release", {20'd0, outs()}, 32'd0);

    // Table: inputs driven just after edge i, outputs checked just after edge i+1.
    for (int i = 0; i < 29; i++) begin
      key_n    = vecs[i].key_n;
      rdy_xfer = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d", i), {20'd0, outs()},
          {20'd0, vecs[i].xfer, vecs[i].busy, vecs[i].denied, vecs[i].terr, vecs[i].cnt});
    end

    // Bounce rejection with rdy high.
    key_n = 1'b1;
    repeat (10) step();
    rdy_xfer = 1'b1;
    any_act  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      key_n = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      any_act = any_act | xfer | denied | busy;
    end
    key_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      any_act = any_act | xfer | denied | busy;
    end
    chk("bounce_quiet", {31'd0, any_act}, 32'd0);
    chk("bounce_count", {24'd0, xfer_count}, 32'd1);

    // Drop exactly on the final counter cycle counts as success.
    key_n = 1'b0;
    wait_xfer("boundary_fire");
    repeat (63) step();
    chk("boundary_busy_before", {31'd0, busy}, 32'd1);
    rdy_xfer = 1'b0;
    step();
    chk("boundary_done", {20'd0, outs()}, {20'd0, 4'b0000, 8'd2});
    key_n = 1'b1;
    repeat (10) step();
    rdy_xfer = 1'b1;

    // Timeout: IDLE 64 cycles after FIRE, sticky error, count unchanged.
    key_n = 1'b0;
    wait_xfer("timeout_fire");
    repeat (63) step();
    chk("timeout_busy_before", {31'd0, busy}, 32'd1);
    step();
    chk("timeout_done", {20'd0, outs()}, {20'd0, 4'b0001, 8'd2});
    key_n = 1'b1;
    repeat (10) step();
    do_xfer();
    chk("after_timeout_success", {20'd0, outs()}, {20'd0, 4'b0001, 8'd3});

    // Wrap after 256 successes from a fresh reset.
    apply_reset();
    chk("wrap_reset", {20'd0, outs()}, 32'd0);
    for (int n = 0; n < 255; n++) do_xfer();
    chk("wrap_255", {24'd0, xfer_count}, 32'd255);
    do_xfer();
    chk("wrap_0", {20'd0, outs()}, 32'd0);

    // Reset asserted during FIRE truncates the pulse; held key needs a fresh debounce.
    rdy_xfer = 1'b1;
    key_n    = 1'b0;
    wait_xfer("rst_fire");
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_fire", {20'd0, outs()}, 32'd0);
    rdy_xfer = 1'b0;
    step();
    reset   = 1'b1;
    any_act = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      any_act = any_act | xfer | denied | busy;
    end
    chk("rst_no_early_event", {31'd0, any_act}, 32'd0);
    step();
    chk("rst_fresh_press_denied", {20'd0, outs()}, {20'd0, 4'b0010, 8'd0});
    any_act = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      any_act = any_act | xfer | denied | busy;
    end
    chk("rst_held_single_event", {31'd0, any_act}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
